mult: RTL and testbench
=======================

Name: mult

Overview:
- Sequential signed multiplier for the multicycle processor. Companion to the restoring divider: the inverse operation.
- Executes MULT by radix-2 Booth recoding, one bit per clock, and produces a 2*WIDTH-bit product split into hi/lo for the HI/LO registers.
- Uses the same start/busy/done handshake as the divider, so the control unit drives both blocks identically.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-low reset (0 = reset)
- start  input   1      request; accepted only when busy=0
- a      input   WIDTH  multiplicand, two's complement
- b      input   WIDTH  multiplier, two's complement
- busy   output  1      operation in progress
- done   output  1      one-cycle pulse; hi/lo valid
- hi     output  WIDTH  product[2W-1:W]
- lo     output  WIDTH  product[W-1:0]

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-operation): busy=0, done=0, hi=0, lo=0. Iteration counter and internal registers are cleared. Any in-flight operation is discarded. Operation resumes on the first edge after rst returns to 1.
- States: IDLE, RUN, FIN.
- IDLE: at an edge with start=1:
  - latch M=a (sign-extended to W+1 bits).
  - load the accumulator with {A=0 (W+1 bits), Q=b, Q-1=0}.
  - set counter=0, busy=1, go to RUN.
  - a and b are sampled only at this edge; later changes are ignored.
- RUN, each edge, on {Q[0],Q-1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00/11: A unchanged.
  - then arithmetic-shift {A,Q,Q-1} right by 1 (sign of A preserved); counter++.
  - after W iterations, go to FIN.
- The W+1-bit A is mandatory. A W-bit A overflows for M=-2^(W-1).
- FIN (one edge):
  - hi = {A,Q}[2W-1:W], lo = Q (the low W bits of {A,Q}).
  - done=1, busy=0, return to IDLE.
- Latency: start edge E0 → busy=1 after E0 → done=1 and busy=0 after edge E(W+1) (E33 for W=32). Each operation takes W+2 edges including the accept edge.
- done is high for exactly one cycle and is cleared at every edge where FIN is not being exited.
- hi/lo hold their value until the next completion or reset. They do not change during RUN.
- start while busy=1: ignored, no effect on the current operation.
- start in the cycle where done=1: busy is already 0, so it is accepted at that edge and back-to-back operations are legal.
- No dbz or overflow output. The full product is always exact, including -2^(W-1) * -2^(W-1) = 2^(2W-2).
- Operands of zero still take the full W+2 cycles. There is no early termination, so latency is fixed.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → busy=0, done=0, hi=0, lo=0. start=0 for 5 cycles → outputs unchanged.
- Basic positive: a=7, b=6 → done after E33, hi=0x00000000, lo=0x0000002A. Check busy high for exactly 33 cycles and done for exactly 1.
- Mixed and negative signs:
  - a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- Extremes:
  - a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
  - a=0x7FFFFFFF, b=0x80000000 → hi=0xC0000000, lo=0x80000000.
- Handshake:
  - start pulsed again at cycle 10 with a=9, b=9 → ignored; first result (7*6) is unaffected.
  - start held high in the done cycle with a=2, b=3 → second op accepted, done 33 edges later with lo=6. Operand changes during RUN have no effect.
- Reset mid-operation: start a=100, b=100, assert rst=0 at cycle 15 → busy=0 and done=0 immediately (asynchronous), hi=lo=0, no done pulse follows. A new start 1 cycle after release gives the correct result.

Source files
------------

// File: rtl/mult.sv
// Sequential signed multiplier: radix-2 Booth recoding, one multiplier bit per clock.
// Shares the start/busy/done handshake of the restoring divider; product is split into hi/lo.
module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_reg;
    // A and M carry one extra bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH:0]   sum;

    always_comb begin
        sum = acc_reg;
        case ({q_reg[0], q_m1_reg})
            2'b01:   sum = acc_reg + m_reg;
            2'b10:   sum = acc_reg - m_reg;
            default: sum = acc_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            q_m1_reg  <= 1'b0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg     <= {a[WIDTH-1], a};
                        acc_reg   <= '0;
                        q_reg     <= b;
                        q_m1_reg  <= 1'b0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Arithmetic shift of {A,Q,Q-1} after the Booth add/subtract.
                    acc_reg   <= {sum[WIDTH], sum[WIDTH:1]};
                    q_reg     <= {sum[0], q_reg[WIDTH-1:1]};
                    q_m1_reg  <= q_reg[0];
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    hi_reg    <= acc_reg[WIDTH-1:0];
                    lo_reg    <= q_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: spec vector table, randomized ops against a plain
// signed-multiply model, and hand-written handshake / reset sequences.
module tb_mult;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    mult #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = $signed({{W{x[W-1]}}, x});
        sy = $signed({{W{y[W-1]}}, y});
        return sx * sy;
    endfunction

    // Caller is at a negedge. Launches an op, scrambles operands during RUN, optionally
    // pokes start at cycle 10, and returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input bit poke,
                          output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output int cycles, output int busy_n, output bit held, output bit got_done);
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        start = 1'b1;
        a = opa;
        b = opb;
        @(posedge clk);
        #1 start = 1'b0;
        hold_hi = hi;
        hold_lo = lo;
        cycles = 0;
        busy_n = 0;
        held = 1'b1;
        got_done = 1'b0;
        for (int n = 1; n <= W + 10; n++) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (hi !== hold_hi || lo !== hold_lo) held = 1'b0;
            a = $urandom;
            b = $urandom;
            start = 1'b0;
            if (poke && n == 10) begin
                start = 1'b1;
                a = 9;
                b = 9;
            end
        end
        start = 1'b0;
        rhi = hi;
        rlo = lo;
    endtask

    task automatic do_op(input string name, input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input bit poke);
        logic [W-1:0] rhi;
        logic [W-1:0] rlo;
        logic [63:0]  exp;
        int cycles;
        int busy_n;
        bit held;
        bit got_done;
        exp = model(opa, opb);
        run_op(opa, opb, poke, rhi, rlo, cycles, busy_n, held, got_done);
        check({name, " done_seen"}, 64'(got_done), 64'd1);
        check({name, " product"}, {rhi, rlo}, exp);
        check({name, " latency"}, 64'(cycles), 64'(W + 2));
        check({name, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
        check({name, " hilo_held"}, 64'(held), 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           bad;

        vecs[0] = '{32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[5] = '{32'd0,        32'h8000_0000, 32'h0000_0000, 32'h0000_0000};

        // Reset then idle
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done || hi != 0 || lo != 0) bad = 1'b1;
        end
        check("idle outputs", 64'(bad), 64'd0);

        // Spec vectors; table product compared too so the model itself is exercised
        for (int i = 0; i < 6; i++) begin
            check($sformatf("model v%0d", i), model(vecs[i].va, vecs[i].vb),
                  {vecs[i].ehi, vecs[i].elo});
            do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, 1'b0);
            $display("vec%0d a=%h b=%h hi=%h lo=%h", i, vecs[i].va, vecs[i].vb, hi, lo);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
        end

        // Start re-pulsed mid-operation must be ignored; then back-to-back op in the done cycle
        do_op("poke 7x6", 32'd7, 32'd6, 1'b1);
        $display("poke a=7 b=6 hi=%h lo=%h", hi, lo);
        do_op("b2b 2x3", 32'd2, 32'd3, 1'b1);
        $display("b2b a=2 b=3 hi=%h lo=%h", hi, lo);
        @(negedge clk);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'h7FFF_FFFF;
            if (i == 2) ra = 32'd0;
            do_op($sformatf("rand%0d", i), ra, rb, 1'b0);
            $display("rand%0d a=%h b=%h hi=%h lo=%h", i, ra, rb, hi, lo);
        end
        @(negedge clk);

        // Reset mid-operation, then verify nothing completes afterwards
        start = 1'b1;
        a = 100;
        b = 100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        check("midreset no_done", 64'(bad), 64'd0);
        $display("midreset a=100 b=100 discarded");

        // Reset mid-operation, then restart one cycle after release
        start = 1'b1;
        a = 100;
        b = 100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("restart", 32'hFFFF_CFC7, 32'd678, 1'b0);
        $display("restart a=%h b=%h hi=%h lo=%h", 32'hFFFF_CFC7, 32'd678, hi, lo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
